// File: rtl/edu_tx_bridge_if.sv
// ============================================================================
//  Module      : edu_tx_bridge_if
//  Description : Bundles the producer valid/ready channel and the edu 4-phase
//                bundled-data channel that pass through edu_tx_bridge.
//                The master modport is the bridge's view. The slave modport is
//                the view of the environment: the producer plus the edu stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface edu_tx_bridge_if #(
  parameter int WIDTH = 7
) ();

  // Producer side (synchronous valid/ready)
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  // edu side (4-phase bundled data; ack_in is asynchronous to clk)
  logic             req_out;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    input  in_valid,
    input  in_data,
    input  ack_in,
    output in_ready,
    output req_out,
    output data_out
  );

  modport slave (
    output in_valid,
    output in_data,
    output ack_in,
    input  in_ready,
    input  req_out,
    input  data_out
  );

endinterface

`default_nettype wire

// File: rtl/edu_tx_bridge.sv
// ============================================================================
//  Module      : edu_tx_bridge
//  Description : Clocked-to-asynchronous bridge. Words from a valid/ready
//                producer are buffered in a small FIFO. Each word is then sent
//                on a 4-phase req/ack bundled-data channel to the edu stage.
//                ack_in is synchronised internally before the FSM uses it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edu_tx_bridge #(
  parameter int WIDTH       = 7,
  parameter int DEPTH       = 4,
  parameter int SETUP_CYC   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  edu_tx_bridge_if.master    bus,
  output      logic [15:0]   sent_count,
  output      logic          busy
);

  // --------------------------------------------------------------------------
  // Derived sizes
  // --------------------------------------------------------------------------
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  // The setup counter only has to hold SETUP_CYC-1.
  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  localparam logic [CW-1:0] c_setupLoad = CW'(SETUP_CYC - 1);

  // FSM encoding
  localparam logic [1:0] c_stIdle      = 2'd0;
  localparam logic [1:0] c_stSetup     = 2'd1;
  localparam logic [1:0] c_stWaitAckHi = 2'd2;
  localparam logic [1:0] c_stWaitAckLo = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [PW-1:0]          r_wrPtr;
  logic [PW-1:0]          r_rdPtr;
  logic [SYNC_STAGES-1:0] r_ackSync;
  logic [1:0]             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_req;
  logic [WIDTH-1:0]       r_data;
  logic [15:0]            r_sentCount;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_ackS;

  // --------------------------------------------------------------------------
  // FIFO status
  // --------------------------------------------------------------------------
  // The pointers carry one extra wrap bit. This separates full from empty
  // when the index bits are equal.
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]) &&
                   (r_wrPtr[AW] != r_rdPtr[AW]);

  // in_ready comes only from registered occupancy. There is no same-cycle
  // bypass, so a pop on this edge does not open a slot until the next cycle.
  assign bus.in_ready = !w_full;
  assign w_push       = bus.in_valid && !w_full;

  // A word leaves the FIFO only when the FSM loads it into data_out.
  assign w_ackS = r_ackSync[SYNC_STAGES-1];
  assign w_pop  = (r_state == c_stIdle) && !w_empty && !w_ackS;

  // FIFO storage: written on accepted pushes only. It needs no reset, because
  // a cleared pointer pair already makes every entry invisible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr[AW-1:0]] <= bus.in_data;
    end
  end

  // FIFO pointers: both advance by natural overflow, so order is strictly FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Ack synchroniser
  // --------------------------------------------------------------------------
  // Shift the asynchronous ack_in through SYNC_STAGES flops. Only the last
  // stage reaches the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ackSync <= '0;
    end else begin
      r_ackSync <= {r_ackSync[SYNC_STAGES-2:0], bus.ack_in};
    end
  end

  // --------------------------------------------------------------------------
  // 4-phase handshake FSM
  // --------------------------------------------------------------------------
  // Load a word, hold it for the setup margin, raise req, then wait for ack to
  // rise and fall. data_out changes only in the IDLE load step, so it stays
  // stable for the whole handshake. If ack is stale-high in IDLE, the next load
  // is held back until the synchronised ack returns low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_stIdle;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_data      <= '0;
      r_sentCount <= '0;
    end else begin
      case (r_state)
        c_stIdle: begin
          if (w_pop) begin
            r_data  <= r_mem[r_rdPtr[AW-1:0]];
            r_cnt   <= c_setupLoad;
            r_state <= c_stSetup;
          end
        end
        c_stSetup: begin
          if (r_cnt == '0) begin
            r_req   <= 1'b1;
            r_state <= c_stWaitAckHi;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        c_stWaitAckHi: begin
          if (w_ackS) begin
            r_req   <= 1'b0;
            r_state <= c_stWaitAckLo;
          end
        end
        c_stWaitAckLo: begin
          if (!w_ackS) begin
            // The count wraps from 0xFFFF back to 0 with no special handling.
            r_sentCount <= r_sentCount + 16'd1;
            r_state     <= c_stIdle;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= c_stIdle;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.req_out  = r_req;
  assign bus.data_out = r_data;
  assign sent_count   = r_sentCount;
  assign busy         = (r_state != c_stIdle) || !w_empty;

endmodule

`default_nettype wire

// File: tb/tb_edu_tx_bridge.sv
// ============================================================================
//  Module      : tb_edu_tx_bridge
//  Description : Scoreboard bench for edu_tx_bridge. Stimulus pushes expected
//                words into a queue. A monitor pops the queue on every rising
//                req_out and compares the word. A behavioural edu bucket
//                answers req with ack after a programmable delay.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_edu_tx_bridge;

  localparam int WIDTH       = 7;
  localparam int DEPTH       = 4;
  localparam int SETUP_CYC   = 1;
  localparam int SYNC_STAGES = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] sentCount;
  logic        busy;

  edu_tx_bridge_if #(.WIDTH(WIDTH)) bus ();

  edu_tx_bridge #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .SETUP_CYC  (SETUP_CYC),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sent_count(sentCount),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard
  int nChecks = 0;
  int nPass   = 0;
  logic [WIDTH-1:0] expQ [$];
  int expSent = 0;

  // edu bucket model
  logic ackRsp   = 1'b0;
  logic forceAck = 1'b0;
  int   ackDelay = 0;
  int   rspCnt   = 0;
  assign bus.ack_in = ackRsp | forceAck;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    else nPass++;
  endtask

  // edu bucket: raise ack ackDelay cycles after req is seen, drop it after req falls
  always @(negedge clk) begin
    if (!rst_n) begin
      ackRsp = 1'b0;
      rspCnt = 0;
    end else if (!ackRsp) begin
      if (bus.req_out) begin
        if (rspCnt >= ackDelay) ackRsp = 1'b1;
        else rspCnt++;
      end
    end else if (!bus.req_out) begin
      ackRsp = 1'b0;
      rspCnt = 0;
    end
  end

  // Monitor: check each delivered word, data stability, and that req waits for synchronised ack
  logic             prevReq = 1'b0;
  int               ackHi   = 0;
  logic [WIDTH-1:0] heldData = '0;
  logic [WIDTH-1:0] expWord;
  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prevReq = 1'b0;
      ackHi   = 0;
    end else begin
      ackHi = bus.ack_in ? ackHi + 1 : 0;
      if (bus.req_out && !prevReq) begin
        chk("word expected at req", 32'(expQ.size() > 0), 32'd1);
        if (expQ.size() > 0) begin
          expWord = expQ.pop_front();
          chk("bucket data", 32'(bus.data_out), 32'(expWord));
        end
        heldData = bus.data_out;
      end else if (bus.req_out && prevReq) begin
        chk("data stable", 32'(bus.data_out), 32'(heldData));
      end else if (!bus.req_out && prevReq) begin
        chk("req fall after ack_s", 32'(ackHi >= SYNC_STAGES + 1), 32'd1);
      end
      prevReq = bus.req_out;
    end
  end

  // Push one word (called and returning at a negedge)
  task automatic push(input logic [WIDTH-1:0] d);
    int k;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    k = 0;
    while (!bus.in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("push accepted", 32'(bus.in_ready), 32'd1);
    if (bus.in_ready) begin
      @(posedge clk);
      expQ.push_back(d);
      expSent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Wait for the bridge and the bucket to return to rest, then check the totals
  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((busy || bus.req_out || bus.ack_in) && k < 400) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({nm, " idle"}, 32'(busy || bus.req_out || bus.ack_in), 32'd0);
    chk({nm, " all received"}, 32'(expQ.size()), 32'd0);
    chk({nm, " sent_count"}, 32'(sentCount), 32'(expSent[15:0]));
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] words [10];
  int firstBlock;
  int hiCycles;
  int k;

  initial begin
    words = '{7'h11, 7'h62, 7'h03, 7'h7E, 7'h45, 7'h28, 7'h19, 7'h5A, 7'h00, 7'h3C};
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1;
    chk("reset req_out", 32'(bus.req_out), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1. Idle after reset
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle req_out", 32'(bus.req_out), 32'd0);
      chk("idle in_ready", 32'(bus.in_ready), 32'd1);
      chk("idle busy", 32'(busy), 32'd0);
      chk("idle sent_count", 32'(sentCount), 32'd0);
    end
    @(negedge clk);

    // 2. Single word with an instant-ack bucket: check the latency
    ackDelay     = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 7'h2A;
    @(posedge clk);
    expQ.push_back(7'h2A);
    expSent++;
    #1;
    bus.in_valid = 1'b0;
    chk("t+0 req_out", 32'(bus.req_out), 32'd0);
    @(posedge clk);
    #1;
    chk("t+1 data_out", 32'(bus.data_out), 32'h2A);
    chk("t+1 req_out", 32'(bus.req_out), 32'd0);
    @(posedge clk);
    #1;
    chk("t+2 req_out", 32'(bus.req_out), 32'd1);
    drain("single");

    // 3. Ten words into a slow bucket: backpressure must appear after four buffered words
    ackDelay   = 5;
    firstBlock = -1;
    for (int i = 0; i < 10; i++) begin
      if (!bus.in_ready && firstBlock < 0) firstBlock = i;
      push(words[i]);
    end
    chk("in_ready low after 1 in flight + 4 buffered", 32'(firstBlock), 32'd5);
    chk("busy during burst", 32'(busy), 32'd1);
    drain("burst");

    // 4. Ack delayed by seven clocks: req must stay high until the synchronised ack
    ackDelay = 7;
    push(7'h55);
    k = 0;
    while (!bus.req_out && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    hiCycles = 0;
    while (bus.req_out && hiCycles < 100) begin
      @(posedge clk);
      #1;
      hiCycles++;
    end
    chk("req high long enough", 32'(hiCycles >= 7 + SYNC_STAGES), 32'd1);
    chk("data held after req fall", 32'(bus.data_out), 32'h55);
    drain("slow ack");

    // 5. Reset while waiting for ack
    ackDelay = 20;
    push(7'h33);
    k = 0;
    while (!bus.req_out && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("req raised before reset", 32'(bus.req_out), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid reset req_out", 32'(bus.req_out), 32'd0);
    chk("mid reset in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid reset busy", 32'(busy), 32'd0);
    chk("mid reset data_out", 32'(bus.data_out), 32'd0);
    chk("mid reset sent_count", 32'(sentCount), 32'd0);
    expQ.delete();
    expSent = 0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    ackDelay = 0;
    @(negedge clk);
    push(7'h15);
    drain("after reset");

    // 6. sent_count wraps 0xFFFF -> 0
    @(negedge clk);
    force dut.r_sentCount = 16'hFFFF;
    @(negedge clk);
    release dut.r_sentCount;
    @(negedge clk);
    chk("forced count", 32'(sentCount), 32'hFFFF);
    expSent = 32'hFFFF;
    push(7'h7F);
    expSent = 0;
    drain("wrap");

    // 7. Stale ack high in IDLE blocks a new request until it clears
    forceAck = 1'b1;
    repeat (4) @(negedge clk);
    push(7'h4B);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("no req while ack high", 32'(bus.req_out), 32'd0);
    end
    chk("busy with stale ack", 32'(busy), 32'd1);
    @(negedge clk);
    forceAck = 1'b0;
    drain("stale ack");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
